ff_stim_seq: RTL and testbench
==============================

// Module: ff_stim_seq
// PURPOSE
//   Stimulus sequencer that sits directly upstream of the flip-flop mapping test DUT.
//   It drives the DUT's shared reset and enable pins through a fixed, repeatable pattern:
//   reset hold, enable high, enable low, pseudo-random enable, then a one-cycle reset mid-run.
//   Every output comes straight from a flop, so the DUT sees glitch-free, clk-aligned edges.
// PARAMETERS
//   HOLD_CYCLES   4      cycles in HOLD; legal range 1..2**CNT_W
//   PHASE_CYCLES  16     cycles in each of EN_HI, EN_LO and RAND; legal range 1..2**CNT_W
//   LFSR_SEED     8'hA5  value loaded into the LFSR on entry to RAND; 8'h00 is replaced by 8'h01
//   DUT_RST_HIGH  1      1: dut_reset is asserted high; 0: dut_reset is asserted low
//   CNT_W         8      width of cycle_cnt
// PORTS
//   clk        in   1      single clock; all state changes on posedge clk
//   reset      in   1      asynchronous, active-low reset
//   start      in   1      level, sampled each clk; in IDLE, launches one sequence
//   abort      in   1      level; in any state other than IDLE, returns to IDLE next edge
//   dut_enable out  1      enable pin of the DUT
//   dut_reset  out  1      reset pin of the DUT, polarity set by DUT_RST_HIGH
//   phase      out  3      current state encoding
//   cycle_cnt  out  CNT_W  cycle count within the current state
//   busy       out  1      1 in every state other than IDLE
//   done       out  1      one-cycle pulse on normal completion
// BEHAVIOUR
//   Reset (reset=0, async):
//     phase=IDLE, cycle_cnt=0, dut_enable=0, dut_reset asserted, busy=0, done=0, lfsr=seed.
//   States and encodings:
//     IDLE=0, HOLD=1, EN_HI=2, EN_LO=3, RAND=4, MIDRST=5. Codes 6 and 7 go to IDLE on the next edge.
//   IDLE:   dut_reset asserted, dut_enable=0. start=1 and abort=0 -> HOLD.
//   HOLD:   dut_reset asserted, dut_enable=0. Lasts HOLD_CYCLES, then -> EN_HI.
//   EN_HI:  dut_reset deasserted, dut_enable=1. Lasts PHASE_CYCLES, then -> EN_LO.
//   EN_LO:  dut_reset deasserted, dut_enable=0. Lasts PHASE_CYCLES, then -> RAND.
//   RAND:   dut_reset deasserted, dut_enable=lfsr[0]. Lasts PHASE_CYCLES, then -> MIDRST.
//   MIDRST: dut_reset asserted and dut_enable=1 for exactly 1 cycle, then -> IDLE with done=1.
//   Dwell counting:
//     cycle_cnt clears to 0 on every state change and increments otherwise.
//     A state exits on the edge where cycle_cnt==N-1. cycle_cnt holds at 0 in IDLE.
//   LFSR:
//     8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, feedback mask 8'hB8.
//     Update: lfsr <= lfsr[0] ? (lfsr>>1)^8'hB8 : lfsr>>1.
//     Loaded with the seed on the edge that enters RAND; advances on each RAND edge; holds in all other states.
//   Output timing:
//     dut_enable, dut_reset, phase, busy and done are registered from the next-state decode,
//     so they change on the same edge as the state register (0-cycle lag from state).
//   Sequence length:
//     start sampled at edge E0 -> HOLD from E0; EN_HI from E0+4; EN_LO from E0+20;
//     RAND from E0+36; MIDRST at E0+52; IDLE with done=1 at E0+53; done=0 at E0+54.
//   Priority and boundary cases:
//     start while busy: ignored.
//     start and abort together in IDLE: abort wins, stay in IDLE.
//     abort in any non-IDLE state: next edge -> IDLE, dut_reset asserted, done=0.
//     start held high continuously: one new sequence launches on the edge after done.
//     reset mid-sequence: immediate return to the reset values listed above, no done pulse.
// TESTING
//   T1 Reset:
//     reset=0 with start=1 -> phase=0, dut_reset=1, dut_enable=0, busy=0, done=0 while reset is low.
//   T2 Full sequence (defaults):
//     1-cycle start pulse -> HOLD 4 cycles, EN_HI 16 cycles with enable=1, EN_LO 16 cycles with enable=0;
//     dut_reset=1 only in HOLD and MIDRST; done pulses once, 53 edges after start.
//   T3 LFSR:
//     seed 8'hA5 -> first four RAND cycles give dut_enable=1,0,1,0 (lfsr=A5,EA,75,82).
//   T4 Abort:
//     abort at EN_LO cycle_cnt=5 -> next edge phase=0, dut_reset=1, dut_enable=0; done never pulses.
//   T5 Collisions:
//     start+abort together in IDLE -> stays IDLE.
//     start pulsed during EN_HI -> ignored; sequence timing unchanged.
//   T6 Async reset mid-run:
//     reset=0 asserted between edges during RAND -> outputs return to reset values before the next edge.
//     After release, start relaunches with the LFSR reloaded to A5.

Source files
------------

// File: rtl/ff_stim_seq.sv
// ff_stim_seq: stimulus sequencer for the flip-flop mapping test DUT.
// It walks the DUT's shared reset/enable pins through a fixed pattern:
// reset hold, enable high, enable low, pseudo-random enable and a
// one-cycle reset pulse. Every output is taken directly from a flop so
// the DUT only ever sees clean, clock-aligned edges.
module ff_stim_seq #(
    parameter int         HOLD_CYCLES  = 4,
    parameter int         PHASE_CYCLES = 16,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    parameter bit         DUT_RST_HIGH = 1'b1,
    parameter int         CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             dut_enable,
    output logic             dut_reset,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_EN_HI  = 3'd2,
        ST_EN_LO  = 3'd3,
        ST_RAND   = 3'd4,
        ST_MIDRST = 3'd5
    } state_t;

    // An all-zero seed would lock the LFSR at zero, so it is swapped for 1.
    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] LFSR_MASK = 8'hB8;

    // Terminal counts: a state leaves on the edge where cycle_cnt hits N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);

    // Asserted / deasserted levels of the DUT reset pin.
    localparam logic RST_ON  = DUT_RST_HIGH;
    localparam logic RST_OFF = ~DUT_RST_HIGH;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       lfsr_q;
    logic [7:0]       lfsr_d;
    logic             dwell_end;
    logic             enable_d;
    logic             dut_reset_d;
    logic             busy_d;
    logic             done_d;
    logic             enable_q;
    logic             dut_reset_q;
    logic             busy_q;
    logic             done_q;

    // One Galois step of x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        return value[0] ? ((value >> 1) ^ LFSR_MASK) : (value >> 1);
    endfunction

    // Detect the last cycle of whichever timed state we are in.
    always_comb begin
        dwell_end = 1'b0;
        case (state_q)
            ST_HOLD:  dwell_end = (cnt_q == HOLD_LAST);
            ST_EN_HI: dwell_end = (cnt_q == PHASE_LAST);
            ST_EN_LO: dwell_end = (cnt_q == PHASE_LAST);
            ST_RAND:  dwell_end = (cnt_q == PHASE_LAST);
            default:  dwell_end = 1'b0;
        endcase
    end

    // Next-state decode; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = (start && !abort) ? ST_HOLD : ST_IDLE;
            ST_HOLD:   state_d = dwell_end ? ST_EN_HI : ST_HOLD;
            ST_EN_HI:  state_d = dwell_end ? ST_EN_LO : ST_EN_HI;
            ST_EN_LO:  state_d = dwell_end ? ST_RAND  : ST_EN_LO;
            ST_RAND:   state_d = dwell_end ? ST_MIDRST : ST_RAND;
            ST_MIDRST: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && abort) begin
            state_d = ST_IDLE;
        end
    end

    // Dwell counter and LFSR next values.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        lfsr_d = lfsr_q;
        if (state_d != state_q || state_q == ST_IDLE) begin
            cnt_d = '0;
        end
        if (state_d == ST_RAND && state_q != ST_RAND) begin
            lfsr_d = SEED_EFF;
        end else if (state_q == ST_RAND) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // Pin levels decoded from the state being entered, so that the flops
    // below switch on the same edge as the state register.
    always_comb begin
        enable_d    = 1'b0;
        dut_reset_d = RST_ON;
        case (state_d)
            ST_IDLE: begin
                enable_d    = 1'b0;
                dut_reset_d = RST_ON;
            end
            ST_HOLD: begin
                enable_d    = 1'b0;
                dut_reset_d = RST_ON;
            end
            ST_EN_HI: begin
                enable_d    = 1'b1;
                dut_reset_d = RST_OFF;
            end
            ST_EN_LO: begin
                enable_d    = 1'b0;
                dut_reset_d = RST_OFF;
            end
            ST_RAND: begin
                enable_d    = lfsr_d[0];
                dut_reset_d = RST_OFF;
            end
            ST_MIDRST: begin
                enable_d    = 1'b1;
                dut_reset_d = RST_ON;
            end
            default: begin
                enable_d    = 1'b0;
                dut_reset_d = RST_ON;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_MIDRST) && !abort;
    end

    // State, counter and LFSR registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= SEED_EFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Output flops driving the DUT pins and status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q    <= 1'b0;
            dut_reset_q <= RST_ON;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            dut_reset_q <= dut_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dut_enable = enable_q;
    assign dut_reset  = dut_reset_q;
    assign phase      = state_q;
    assign cycle_cnt  = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ff_stim_seq.sv
// tb_ff_stim_seq: directed bench for ff_stim_seq with default parameters.
// A timeline model (cycles since launch) produces the expected outputs for
// each edge; they are queued when the inputs are driven and popped and
// compared once the DUT has clocked.
module tb_ff_stim_seq;

    typedef struct packed {
        logic [2:0] phase;
        logic [7:0] cnt;
        logic       en;
        logic       rst;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       dut_enable;
    logic       dut_reset;
    logic [2:0] phase;
    logic [7:0] cycle_cnt;
    logic       busy;
    logic       done;

    int   compared   = 0;
    int   mismatched = 0;
    int   seq_k      = -1;
    logic exp_done   = 1'b0;
    exp_t sb[$];

    ff_stim_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .dut_enable (dut_enable),
        .dut_reset  (dut_reset),
        .phase      (phase),
        .cycle_cnt  (cycle_cnt),
        .busy       (busy),
        .done       (done)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] lfsrAdvance(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    // Expected outputs k cycles into a sequence (k < 0 means idle).
    function automatic exp_t expectFor(input int k, input logic d);
        exp_t e;
        logic [7:0] l;
        e = '0;
        if (k < 0) begin
            e.rst  = 1'b1;
            e.done = d;
        end else if (k < 4) begin
            e.phase = 3'd1; e.cnt = 8'(k);      e.rst = 1'b1; e.busy = 1'b1;
        end else if (k < 20) begin
            e.phase = 3'd2; e.cnt = 8'(k - 4);  e.en = 1'b1;  e.busy = 1'b1;
        end else if (k < 36) begin
            e.phase = 3'd3; e.cnt = 8'(k - 20); e.busy = 1'b1;
        end else if (k < 52) begin
            l = 8'hA5;
            for (int i = 0; i < k - 36; i++) l = lfsrAdvance(l);
            e.phase = 3'd4; e.cnt = 8'(k - 36); e.en = l[0]; e.busy = 1'b1;
        end else begin
            e.phase = 3'd5; e.en = 1'b1; e.rst = 1'b1; e.busy = 1'b1;
        end
        return e;
    endfunction

    // Advance the timeline model by one edge for the given inputs.
    task automatic modelStep(input logic s, input logic a);
        exp_done = 1'b0;
        if (seq_k < 0) begin
            if (s && !a) seq_k = 0;
        end else if (a) begin
            seq_k = -1;
        end else if (seq_k == 52) begin
            seq_k    = -1;
            exp_done = 1'b1;
        end else begin
            seq_k = seq_k + 1;
        end
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s.queue got empty scoreboard want one entry", tag);
        end else begin
            e = sb.pop_front();
            compared++;
            assert (phase === e.phase) else begin
                mismatched++;
                $error("[TB] FAIL %s.phase got %0d want %0d", tag, phase, e.phase);
            end
            compared++;
            assert (cycle_cnt === e.cnt) else begin
                mismatched++;
                $error("[TB] FAIL %s.cycle_cnt got %0d want %0d", tag, cycle_cnt, e.cnt);
            end
            compared++;
            assert (dut_enable === e.en) else begin
                mismatched++;
                $error("[TB] FAIL %s.dut_enable got %b want %b", tag, dut_enable, e.en);
            end
            compared++;
            assert (dut_reset === e.rst) else begin
                mismatched++;
                $error("[TB] FAIL %s.dut_reset got %b want %b", tag, dut_reset, e.rst);
            end
            compared++;
            assert (busy === e.busy) else begin
                mismatched++;
                $error("[TB] FAIL %s.busy got %b want %b", tag, busy, e.busy);
            end
            compared++;
            assert (done === e.done) else begin
                mismatched++;
                $error("[TB] FAIL %s.done got %b want %b", tag, done, e.done);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, check after the edge.
    task automatic applyStimulus(input logic s, input logic a, input string tag);
        @(negedge clk);
        start = s;
        abort = a;
        modelStep(s, a);
        sb.push_back(expectFor(seq_k, exp_done));
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Check that outputs currently sit at their reset values.
    task automatic checkReset(input string tag);
        sb.push_back(expectFor(-1, 1'b0));
        checkOutput(tag);
    endtask

    // Directed sequence covering reset, full run, LFSR, abort, collisions.
    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        #1;
        reset = 1'b0;
        start = 1'b1;
        #1;
        checkReset("T1_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            checkReset("T1_held");
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        seq_k = -1;

        applyStimulus(1'b1, 1'b1, "T5_start_abort");
        applyStimulus(1'b1, 1'b1, "T5_start_abort");
        applyStimulus(1'b0, 1'b0, "T5_idle");

        applyStimulus(1'b1, 1'b0, "T2_launch");
        repeat (9) applyStimulus(1'b0, 1'b0, "T2_run");
        applyStimulus(1'b1, 1'b0, "T5_busy_start");
        repeat (46) applyStimulus(1'b0, 1'b0, "T2_T3_run");

        applyStimulus(1'b1, 1'b0, "T4_launch");
        repeat (25) applyStimulus(1'b0, 1'b0, "T4_run");
        applyStimulus(1'b0, 1'b1, "T4_abort");
        repeat (3) applyStimulus(1'b0, 1'b0, "T4_after");

        repeat (60) applyStimulus(1'b1, 1'b0, "held_start");
        applyStimulus(1'b0, 1'b1, "held_abort");
        applyStimulus(1'b0, 1'b0, "held_idle");

        applyStimulus(1'b1, 1'b0, "T6_launch");
        repeat (40) applyStimulus(1'b0, 1'b0, "T6_run");
        #2;
        reset    = 1'b0;
        seq_k    = -1;
        exp_done = 1'b0;
        #1;
        checkReset("T6_midreset");
        @(posedge clk);
        #1;
        checkReset("T6_held");
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, "T6_relaunch");
        repeat (56) applyStimulus(1'b0, 1'b0, "T6_rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
